// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port round-robin RAM arbiter.
package ram_arb_pkg;

  // Lock ownership of the RAM.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  // Requester ids, also used as the tie-break priority value.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid/port-id shift register that follows each granted read through the
// RAM latency, so the returning data can be steered to the right port.
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_id,
  output logic out_valid,
  output logic out_id
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] id_q;

  // Advance every tag one stage per cycle; reset drops all in-flight reads.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage
    // samples the previous stage's old value, giving a true shift register.
    if (rst) begin
      valid_q <= '0;
      id_q    <= {RD_LAT{PORT0}};
    end else begin
      valid_q[0] <= push;
      id_q[0]    <= push_id;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_id    = id_q[RD_LAT-1];

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters, with an optional lock for read-modify-write sequences and
// read data returned to the port that issued the read.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW     = 6,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  owner_t        owner_q;
  owner_t        owner_d;
  logic          prio_q;
  logic          pipe_valid;
  logic          pipe_id;
  logic          push_rd;
  logic          push_id;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  // Grant selection: a lock owner excludes the other port, otherwise a lone
  // requester wins and a tie goes to the port named by prio.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value unassigned and infers a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case (owner_q)
        OWN_P0: gnt0 = req0;
        OWN_P1: gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            gnt0 = (prio_q == PORT0);
            gnt1 = (prio_q == PORT1);
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  // Drive the RAM from the winner; an idle bus is held at all zeros.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_en    = 1'b1;
      ram_we    = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (gnt1) begin
      ram_en    = 1'b1;
      ram_we    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end
  end

  // Lock ownership: taken only together with a grant, released the edge the
  // owner's lock is seen low.
  always_comb begin
    owner_d = owner_q;
    unique case (owner_q)
      OWN_NONE: begin
        if (gnt0 && lock0)      owner_d = OWN_P0;
        else if (gnt1 && lock1) owner_d = OWN_P1;
      end
      OWN_P0:  if (!lock0) owner_d = OWN_NONE;
      OWN_P1:  if (!lock1) owner_d = OWN_NONE;
      default: owner_d = OWN_NONE;
    endcase
  end

  // Arbitration state: prio always moves to the loser of the last grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      prio_q  <= PORT0;
    end else begin
      owner_q <= owner_d;
      if (gnt0)      prio_q <= PORT1;
      else if (gnt1) prio_q <= PORT0;
    end
  end

  assign push_rd = ram_en & ~ram_we;
  assign push_id = gnt1 ? PORT1 : PORT0;

  rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .push     (push_rd),
    .push_id  (push_id),
    .out_valid(pipe_valid),
    .out_id   (pipe_id)
  );

  // The pipe is only cleared at the reset edge, so the strobes are also
  // masked combinationally while rst is high.
  assign rvalid0 = pipe_valid & (pipe_id == PORT0) & ~rst;
  assign rvalid1 = pipe_valid & (pipe_id == PORT1) & ~rst;

  // Capture returned data per port so it stays visible after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= ram_rdata;
      if (rvalid1) rdata1_q <= ram_rdata;
    end
  end

  assign rdata0 = rst ? '0 : (rvalid0 ? ram_rdata : rdata0_q);
  assign rdata1 = rst ? '0 : (rvalid1 ? ram_rdata : rdata1_q);

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Shares one single-port synchronous RAM (the lab's 32-bit data RAM) between two requesters, e.g. the sequencing datapath (port 0) and a debug/display reader (port 1).
- Round-robin arbitration with one grant per cycle.
- Optional lock lets the granted requester hold the RAM for read-modify-write sequences.
- Tracks read latency and returns data tagged to the requester that issued the read.

Parameters:
- AW, 6, RAM address width (64 words).
- DW, 32, data width.
- RD_LAT, 1, RAM read latency in cycles; legal values are 1 and 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req0, req1  in  1  access request from port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read; qualified by req.
- addr0, addr1  in  AW  word address.
- wdata0, wdata1  in  DW  write data.
- lock0, lock1  in  1  keep ownership after the current grant.
- gnt0, gnt1  out  1  combinational grant; the access is performed this cycle.
- rvalid0, rvalid1  out  1  read data valid for that port.
- rdata0, rdata1  out  DW  read data for that port.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid RD_LAT cycles after a read.

Behaviour:
- State:
  - prio (1 bit): the port that wins a tie.
  - owner (2 bits): NONE, P0 or P1.
  - rd_pipe: RD_LAT stages of {valid, port id}.
- Reset (synchronous, while rst=1):
  - prio=0, owner=NONE, rd_pipe cleared.
  - All gnt, rvalid and ram_en/ram_we are 0.
  - rdata0/rdata1 = 0.
  - ram_addr/ram_wdata = 0.
- Grant selection, combinational, in priority order:
  1. If owner=Px, only Px can be granted, and only when reqx=1. The other port waits even if the owner is idle.
  2. Otherwise, with one requester only, that requester is granted.
  3. Otherwise, with both requesting, port prio is granted.
- At most one gnt is high; gnt0 & gnt1 is never 1.
- RAM drive in a granted cycle:
  - ram_en=1, ram_we=we of the winner, ram_addr/ram_wdata from the winner.
  - With no grant: ram_en=0, ram_we=0, address/data = 0.
- prio update on any grant: prio <= the loser's index (~winner), whether or not there was contention.
- owner update (registered):
  - On grant to Px with lockx=1: owner <= Px.
  - While owner=Px and lockx=0: owner <= NONE at the clock edge. The release takes effect next cycle and no grant is forced in the cycle lockx is seen low, except by rule 1 if Px is also requesting.
  - A lock raised without a grant is ignored.
- Read return:
  - A granted read pushes {1, winner} into rd_pipe.
  - When the entry reaches stage RD_LAT: rvalidx=1 for exactly one cycle, exactly RD_LAT cycles after the grant edge, and rdatax=ram_rdata in that cycle.
  - Otherwise rvalidx=0 and rdatax keeps its last value (registered hold).
  - Writes produce no rvalid.
- Back-to-back reads, including alternating ports, complete in order at one per cycle with no bubbles.
- Write-then-read to the same address in consecutive cycles returns the new data; RAM write-first behaviour is relied on and no forwarding is done here.
- Reset mid-operation: in-flight reads are dropped (no rvalid), any lock is released and prio returns to 0.
- Request inputs are sampled every cycle. A requester must hold req/addr/data until it sees gnt; a req dropped before gnt is never served.

Decomposition:
- Shared package ram_arb_pkg:
  - owner encoding constants OWN_NONE=2'd0, OWN_P0=2'd1, OWN_P1=2'd2.
  - Port id constants.
- One sub-module: rd_tag_pipe (parameter RD_LAT), the valid/id shift register that generates the rvalid strobes.
- Grant logic stays inline.

Test Plan:
1. Reset then idle: hold rst=1 for 2 cycles, release, no requests for 5 cycles -> all gnt=0, ram_en=0, rvalid=0, rdata0=rdata1=0.
2. Solo write/read:
   - Port 0 writes 0xDEADBEEF to address 5.
   - Next cycle port 0 reads address 5.
   - Required: gnt0=1 in both cycles; rvalid0=1 RD_LAT cycles after the read grant with rdata0=0xDEADBEEF; rvalid1 stays 0.
3. Contention: req0 and req1 both held for 4 cycles after reset -> grants alternate P0,P1,P0,P1 (prio starts at 0).
4. Lock:
   - Port 1 is granted with lock1=1; req0 held for the whole sequence.
   - Port 1 performs a read, then idles 1 cycle, then writes, then drops lock1.
   - Required: gnt0 stays 0 until the cycle after lock1=0 is sampled, then gnt0=1.
5. Interleaved reads:
   - Port 0 reads address 1 (contents 0x11), then port 1 reads address 2 (contents 0x22), in consecutive cycles.
   - Required: rvalid0 with 0x11, then rvalid1 with 0x22 one cycle later; repeat with RD_LAT=2.
6. Reset mid-read: read granted, rst=1 on the next edge -> no rvalid0 appears; owner=NONE and prio=0 after release.
